// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with 2-of-3 majority bit decisions
// feeding a first-word fall-through receive FIFO.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 19200,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        valid,
    input  logic                        ready,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int TW  = $clog2(CPB);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int EW  = DATA_WIDTH + 2;
    localparam logic [TW-1:0] T_S0  = TW'(CPB / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(CPB / 2);
    localparam logic [TW-1:0] T_S2  = TW'(CPB / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(CPB - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                state_q, state_d;
    logic                  rx_m_q, rx_s_q, rx_p_q;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic [3:0]            idx_q, idx_d;
    logic [1:0]            smp_q, smp_d;
    logic                  bit_q, bit_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic                  perr_q, perr_d, ferr_q, ferr_d, push_q, push_d;
    logic                  maj, dec, wrap;

    assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
    assign dec  = tmr_q == T_S2;
    assign wrap = tmr_q == T_END;

    always_comb begin
        state_d = state_q;
        tmr_d   = (state_q == S_IDLE || wrap) ? '0 : tmr_q + TW'(1);
        smp_d   = smp_q;
        smp_d[0] = (tmr_q == T_S0) ? rx_s_q : smp_q[0];
        smp_d[1] = (tmr_q == T_S1) ? rx_s_q : smp_q[1];
        bit_d   = dec ? maj : bit_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        push_d  = 1'b0;
        case (state_q)
            S_IDLE: if (rx_p_q && !rx_s_q) begin
                state_d = S_START;
                idx_d   = '0;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
            end
            S_START: state_d = (dec && maj) ? S_IDLE : wrap ? S_DATA : S_START;
            S_DATA: if (wrap) begin
                sh_d  = {bit_q, sh_q[DATA_WIDTH-1:1]};
                idx_d = (idx_q == 4'(DATA_WIDTH - 1)) ? 4'd0 : idx_q + 4'd1;
                state_d = (idx_q != 4'(DATA_WIDTH - 1)) ? S_DATA : (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (wrap) begin
                perr_d  = (^sh_q) ^ bit_q ^ 1'(PARITY == 2);
                state_d = S_STOP;
            end
            S_STOP: if (dec) begin
                // Leave mid-bit so a start edge right after the last stop bit is caught.
                ferr_d = ferr_q | ~maj;
                if (idx_q == 4'(STOP_BITS - 1)) begin
                    push_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end else if (wrap) begin
                idx_d = idx_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_p_q  <= 1'b1;
            state_q <= S_IDLE;
            tmr_q   <= '0;
            idx_q   <= '0;
            smp_q   <= '0;
            bit_q   <= 1'b0;
            sh_q    <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            push_q  <= 1'b0;
        end else begin
            rx_m_q  <= rx;
            rx_s_q  <= rx_m_q;
            rx_p_q  <= rx_s_q;
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            smp_q   <= smp_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            push_q  <= push_d;
        end
    end

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          ovr_q, full, pop, wr;
    logic [EW-1:0] head;

    assign full = cnt_q == (AW + 1)'(FIFO_DEPTH);
    assign pop  = valid & ready;
    assign wr   = push_q & (~full | pop);
    assign head = mem_q[rp_q];

    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= {sh_q, perr_q, ferr_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            wp_q  <= wr ? wp_q + AW'(1) : wp_q;
            rp_q  <= pop ? rp_q + AW'(1) : rp_q;
            cnt_q <= cnt_q + (AW + 1)'(wr) - (AW + 1)'(pop);
            ovr_q <= push_q & full & ~pop;
        end
    end

    assign valid      = cnt_q != '0;
    assign data_out   = valid ? head[EW-1:2] : '0;
    assign parity_err = valid & head[1];
    assign frame_err  = valid & head[0];
    assign overrun    = ovr_q;
    assign fifo_count = cnt_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames into an 8N1 and an 8E1 receiver, scoreboard checked at each pop.
module tb_uart_rx_fifo;
    localparam int CPB = 16;

    logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, ready = 1'b0;
    logic [7:0] dout;
    logic       perr, ferr, vld, ovr;
    logic [2:0] cnt;
    logic       rx_e = 1'b1, ready_e = 1'b0;
    logic [7:0] dout_e;
    logic       perr_e, ferr_e, vld_e, ovr_e;
    logic [2:0] cnt_e;

    int n_cmp = 0, n_err = 0, n_pop = 0, n_vld = 0, n_ovr = 0, n_pop_e = 0;
    int p0, v0;
    logic [9:0] sb[$];
    logic [9:0] sb_e[$];
    logic [7:0] c3 = 8'hC3;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_WIDTH(8), .CLK_FREQ(16), .BAUD_RATE(1), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n (
        .clk(clk), .rst(rst), .rx(rx), .data_out(dout), .parity_err(perr), .frame_err(ferr),
        .valid(vld), .ready(ready), .overrun(ovr), .fifo_count(cnt)
    );

    uart_rx_fifo #(.DATA_WIDTH(8), .CLK_FREQ(16), .BAUD_RATE(1), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
        .clk(clk), .rst(rst), .rx(rx_e), .data_out(dout_e), .parity_err(perr_e), .frame_err(ferr_e),
        .valid(vld_e), .ready(ready_e), .overrun(ovr_e), .fifo_count(cnt_e)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [10:0] bits, input int n, input bit sel);
        for (int i = 0; i < n; i++) begin
            if (sel) rx_e = bits[i]; else rx = bits[i];
            cyc(CPB);
        end
        if (sel) rx_e = 1'b1; else rx = 1'b1;
    endtask

    task automatic frame_n(input logic [7:0] d, input logic stopb);
        send({1'b0, stopb, d, 1'b0}, 10, 1'b0);
    endtask

    task automatic frame_e(input logic [7:0] d, input logic pb);
        send({1'b1, pb, d, 1'b0}, 11, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!rst && vld) n_vld++;
        if (!rst && ovr) n_ovr++;
        if (!rst && vld && ready) begin
            n_pop++;
            chk("n_sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) chk("n_head", {dout, perr, ferr}, sb.pop_front());
        end
        if (!rst && vld_e && ready_e) begin
            n_pop_e++;
            chk("e_sb_nonempty", 32'(sb_e.size() != 0), 1);
            if (sb_e.size() != 0) chk("e_head", {dout_e, perr_e, ferr_e}, sb_e.pop_front());
        end
    end

    initial begin
        cyc(5);
        chk("rst_valid", vld, 0);
        chk("rst_overrun", ovr, 0);
        chk("rst_count", cnt, 0);
        chk("rst_data", dout, 0);
        chk("rst_perr", perr, 0);
        chk("rst_ferr", ferr, 0);
        rst = 1'b0;
        cyc(CPB);
        ready = 1'b1;
        ready_e = 1'b1;
        p0 = n_pop;
        v0 = n_vld;
        sb.push_back({8'hA5, 2'b00});
        frame_n(8'hA5, 1'b1);
        cyc(2 * CPB);
        chk("a5_pops", n_pop - p0, 1);
        chk("a5_valid_cycles", n_vld - v0, 1);
        chk("a5_count", cnt, 0);
        sb.push_back({8'h00, 2'b00});
        frame_n(8'h00, 1'b1);
        sb.push_back({8'hFF, 2'b00});
        frame_n(8'hFF, 1'b1);
        sb.push_back({8'h3C, 2'b00});
        frame_n(8'h3C, 1'b1);
        cyc(CPB);
        chk("pat_pops", n_pop - p0, 4);
        p0 = n_pop;
        sb.push_back({8'h55, 2'b01});
        frame_n(8'h55, 1'b0);
        rx = 1'b0;
        cyc(3 * CPB);
        chk("brk_pops", n_pop - p0, 1);
        chk("brk_valid", vld, 0);
        rx = 1'b1;
        cyc(CPB);
        sb.push_back({8'h12, 2'b00});
        frame_n(8'h12, 1'b1);
        cyc(CPB);
        chk("brk_next_pops", n_pop - p0, 2);
        p0 = n_pop;
        rx = 1'b0;
        cyc(5);
        rx = 1'b1;
        cyc(3 * CPB);
        chk("glitch_valid", vld, 0);
        chk("glitch_count", cnt, 0);
        chk("glitch_pops", n_pop - p0, 0);
        ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            sb.push_back({8'(i), 2'b00});
            frame_n(8'(i), 1'b1);
            chk("fill_count", cnt, 32'(i));
        end
        chk("fill_head", dout, 8'h01);
        chk("fill_no_ovr", n_ovr, 0);
        frame_n(8'h05, 1'b1);
        cyc(CPB);
        chk("ovr_count", cnt, 4);
        chk("ovr_pulses", n_ovr, 1);
        chk("ovr_head", dout, 8'h01);
        p0 = n_pop;
        ready = 1'b1;
        cyc(8);
        chk("drain_pops", n_pop - p0, 4);
        chk("drain_count", cnt, 0);
        chk("drain_sb_empty", sb.size(), 0);
        ready = 1'b0;
        frame_n(8'h99, 1'b1);
        chk("pre_rst_count", cnt, 1);
        rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = c3[i];
            cyc(CPB);
        end
        rx = c3[3];
        cyc(CPB / 2);
        rst = 1'b1;
        rx = 1'b1;
        cyc(3);
        chk("mid_rst_valid", vld, 0);
        chk("mid_rst_count", cnt, 0);
        chk("mid_rst_data", dout, 0);
        chk("mid_rst_flags", {perr, ferr, ovr}, 0);
        rst = 1'b0;
        p0 = n_pop;
        ready = 1'b1;
        cyc(2 * CPB);
        chk("post_rst_pops", n_pop - p0, 0);
        sb.push_back({8'h3C, 2'b00});
        frame_n(8'h3C, 1'b1);
        cyc(CPB);
        chk("post_rst_frame", n_pop - p0, 1);
        sb_e.push_back({8'h37, 2'b10});
        frame_e(8'h37, 1'b0);
        sb_e.push_back({8'h37, 2'b00});
        frame_e(8'h37, 1'b1);
        sb_e.push_back({8'h03, 2'b00});
        frame_e(8'h03, 1'b0);
        sb_e.push_back({8'h80, 2'b01});
        send({1'b0, 1'b1, 8'h80, 1'b0}, 11, 1'b1);
        cyc(2 * CPB);
        chk("e_pops", n_pop_e, 4);
        chk("e_count", cnt_e, 0);
        chk("end_sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame (5..9).
REQ-002 SHALL have parameter CLK_FREQ, default 50000000, clk frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 19200; CPB = CLK_FREQ/BAUD_RATE clocks per bit, CPB >= 8.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked (1 or 2).
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of 2, >= 2).
REQ-007 SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port data_out, output, DATA_WIDTH, FIFO head data.
REQ-011 SHALL have port parity_err, output, 1, parity error flag of FIFO head.
REQ-012 SHALL have port frame_err, output, 1, stop-bit error flag of FIFO head.
REQ-013 SHALL have port valid, output, 1, FIFO non-empty.
REQ-014 SHALL have port ready, input, 1, consumer accepts head.
REQ-015 SHALL have port overrun, output, 1, one-cycle pulse when a completed frame is dropped.
REQ-016 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, current occupancy.

Function
REQ-017 SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use; rx_s denotes its output.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE: on rx_s 1->0 transition, SHALL clear the bit timer and go to START; a low level without a preceding high SHALL NOT start a frame.
REQ-020 SHALL take each bit value as the 2-of-3 majority of rx_s at timer values CPB/2-1, CPB/2, CPB/2+1; the timer wraps at CPB-1 and advances the bit index.
REQ-021 START: majority 1 SHALL abort to IDLE (false start, nothing pushed); majority 0 SHALL go to DATA at the bit boundary.
REQ-022 DATA: SHALL shift in DATA_WIDTH bits LSB first, then go to PARITY if PARITY != 0, otherwise to STOP.
REQ-023 PARITY: SHALL set parity_err for the frame when the XOR of data bits and the parity bit is not 0 (even) or not 1 (odd).
REQ-024 STOP: SHALL set frame_err if any of STOP_BITS stop-bit majorities is 0; after the final stop-bit decision, SHALL push {data, parity_err, frame_err} in the next cycle and return to IDLE.
REQ-025 Frames with errors SHALL still be pushed with their flags set.
REQ-026 Push latency: valid SHALL rise the cycle after the push when the FIFO was empty.
REQ-027 The FIFO SHALL be first-word fall-through: data_out, parity_err and frame_err reflect the head whenever valid=1.
REQ-028 A pop SHALL occur on a cycle with valid && ready; ready while valid=0 SHALL be ignored.
REQ-029 Push and pop in the same cycle SHALL leave fifo_count unchanged, including when full.
REQ-030 A push while full without a pop SHALL drop the new frame, keep the existing contents, and assert overrun for exactly one cycle.
REQ-031 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL range 0..FIFO_DEPTH.

Reset
REQ-032 While rst=1: FSM=IDLE, synchronizer=1, timer and bit index=0, FIFO emptied; outputs valid=0, overrun=0, fifo_count=0, data_out=0, parity_err=0, frame_err=0.
REQ-033 A reset asserted mid-frame SHALL discard the partial frame; after release, reception SHALL resume only on a new 1->0 edge.

Verification (CPB=16 unless stated)
REQ-034 8N1, send 0xA5, ready=1 -> one valid cycle, data_out=0xA5, parity_err=0, frame_err=0.
REQ-035 PARITY=1, send 0x37 with parity bit 0 (correct value is 1) -> data_out=0x37, parity_err=1, frame_err=0.
REQ-036 Send 0x55 with stop bit 0, then hold rx low for 3 bit times -> entry frame_err=1, no second frame until rx returns high and falls again.
REQ-037 Drive a 5-cycle low glitch on idle rx -> START aborts, valid stays 0, fifo_count=0.
REQ-038 FIFO_DEPTH=4, ready=0, send 0x01..0x05 -> fifo_count=4, overrun pulses once after the 5th frame; draining yields 0x01..0x04 in order.
REQ-039 Assert rst during data bit 3 of 0xC3 -> all outputs at reset values; next frame 0x3C is received correctly.
